// File: rtl/alu_pkg.sv
// alu_pkg: opcode indices, FSM state, shared shift helpers
// for the pipelined EX-stage ALU.
package alu_pkg;

  localparam int OP_NUM  = 16;
  localparam int OP_LUI  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_ADD  = 2;
  localparam int OP_AND  = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_SUB  = 5;
  localparam int OP_SLT  = 6;
  localparam int OP_MUL  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRA  = 9;
  localparam int OP_SRL  = 10;
  localparam int OP_NOR  = 11;
  localparam int OP_SLTU = 12;
  localparam int OP_MULH = 13;
  localparam int OP_DIV  = 14;
  localparam int OP_REM  = 15;

  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_MULH,
    MD_DIV,
    MD_REM
  } md_op_t;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } sh_t;

  function automatic logic [MAX_W-1:0] lui_f(
    input logic [MAX_W-1:0] v,
    input int               w
  );
    return v << (w / 2);
  endfunction

  // Caller pre-extends v: zero for sll/srl, sign for sra.
  function automatic logic [MAX_W-1:0] shift_f(
    input logic [MAX_W-1:0] v,
    input logic [5:0]       sh,
    input sh_t              k
  );
    logic [MAX_W-1:0] r;
    unique case (k)
      SH_SLL:  r = v << sh;
      SH_SRL:  r = v >> sh;
      default: r = $unsigned($signed(v) >>> sh);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle signed multiply/divide
// on magnitudes, sign fixed when the result is handed out.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         abort,
  input  md_op_t       op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  md_op_t        op_q;
  logic          neg_q;
  logic [W-1:0]  hi_q, lo_q, mb_q;
  logic [W-1:0]  hi_d, lo_d;
  logic [W-1:0]  mag_a, mag_b;
  logic          neg_s;
  logic          is_div;

  assign mag_a  = a[W-1] ? -a : a;
  assign mag_b  = b[W-1] ? -b : b;
  assign is_div = op_q[1];
  assign busy   = run_q;
  assign done   = run_q && (cnt_q == CW'(W-1));

  // Result sign: rem follows dividend; div by zero stays all-ones.
  always_comb begin
    neg_s = a[W-1] ^ b[W-1];
    unique case (op)
      MD_DIV:  neg_s = (b == '0) ? 1'b0 : (a[W-1] ^ b[W-1]);
      MD_REM:  neg_s = a[W-1];
      default: neg_s = a[W-1] ^ b[W-1];
    endcase
  end

  // One shift-add or restoring-subtract step.
  always_comb begin
    logic [W:0]   sum;
    logic [W:0]   s;
    logic [W-1:0] sub;
    logic         ge;
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    s   = {hi_q, lo_q[W-1]};
    sub = s[W-1:0] - mb_q;
    ge  = s >= {1'b0, mb_q};
    hi_d = sum[W:1];
    lo_d = {sum[0], lo_q[W-1:1]};
    if (is_div) begin
      hi_d = ge ? sub : s[W-1:0];
      lo_d = {lo_q[W-2:0], ge};
    end
  end

  // Sign-fixed result taken from the final step.
  always_comb begin
    logic [2*W-1:0] prod;
    prod = {hi_d, lo_d};
    if (neg_q) prod = -prod;
    result = '0;
    unique case (op_q)
      MD_MUL:  result = prod[W-1:0];
      MD_MULH: result = prod[2*W-1:W];
      MD_DIV:  result = neg_q ? -lo_d : lo_d;
      default: result = neg_q ? -hi_d : hi_d;
    endcase
  end

  // Operand latch and iteration counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= MD_MUL;
      neg_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      mb_q  <= '0;
    end else if (abort) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      op_q  <= op;
      neg_q <= neg_s;
      hi_q  <= '0;
      if (op[1]) begin
        lo_q <= mag_a;
        mb_q <= mag_b;
      end else begin
        lo_q <= mag_b;
        mb_q <= mag_a;
      end
    end else if (run_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (done) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked EX-stage ALU, single-cycle ops plus
// iterative mul/div, with a one-entry result register.
module alu_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
  parameter int OP_NUM      = 16,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_NUM-1:0]     in_op,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err,
  output logic                  busy
);

  import alu_pkg::*;

  localparam int W = DATA_WIDTH;

  state_t                state_q, state_d;
  logic                  one_hot, is_md;
  logic                  accept, md_start;
  logic                  md_done, md_busy;
  logic [OP_NUM-1:0]     op_sel;
  logic [W-1:0]          alu_res, md_res;
  logic [TAG_WIDTH-1:0]  tag_q;
  md_op_t                md_op;
  logic [MAX_W-1:0]      zx2, sx2;
  logic [5:0]            shamt;
  logic                  lt_s, lt_u;

  assign one_hot  = $onehot(in_op);
  assign op_sel   = one_hot ? in_op : '0;
  assign is_md    = op_sel[OP_MUL] | op_sel[OP_MULH] |
                    op_sel[OP_DIV] | op_sel[OP_REM];
  assign in_ready = (state_q == IDLE) &&
                    (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_md;
  assign busy     = md_busy;

  assign zx2   = MAX_W'(in_src2);
  assign sx2   = MAX_W'($signed(in_src2));
  assign shamt = 6'(in_src1[SHAMT_WIDTH-1:0]);
  assign lt_s  = $signed(in_src1) < $signed(in_src2);
  assign lt_u  = in_src1 < in_src2;

  // Encode the iterative opcode for the mul/div unit.
  always_comb begin
    md_op = MD_MUL;
    unique case (1'b1)
      op_sel[OP_MULH]: md_op = MD_MULH;
      op_sel[OP_DIV]:  md_op = MD_DIV;
      op_sel[OP_REM]:  md_op = MD_REM;
      default:         md_op = MD_MUL;
    endcase
  end

  // Single-cycle datapath; non-one-hot ops fall to zero.
  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      op_sel[OP_LUI]:  alu_res = W'(lui_f(zx2, W));
      op_sel[OP_OR]:   alu_res = in_src1 | in_src2;
      op_sel[OP_ADD]:  alu_res = in_src1 + in_src2;
      op_sel[OP_AND]:  alu_res = in_src1 & in_src2;
      op_sel[OP_XOR]:  alu_res = in_src1 ^ in_src2;
      op_sel[OP_SUB]:  alu_res = in_src1 - in_src2;
      op_sel[OP_SLT]:  alu_res = {{(W-1){1'b0}}, lt_s};
      op_sel[OP_SLL]:  alu_res = W'(shift_f(zx2, shamt, SH_SLL));
      op_sel[OP_SRA]:  alu_res = W'(shift_f(sx2, shamt, SH_SRA));
      op_sel[OP_SRL]:  alu_res = W'(shift_f(zx2, shamt, SH_SRL));
      op_sel[OP_NOR]:  alu_res = ~(in_src1 | in_src2);
      op_sel[OP_SLTU]: alu_res = {{(W-1){1'b0}}, lt_u};
      default:         alu_res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: flush or completion returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (md_start) state_d = BUSY;
      BUSY:    if (flush || md_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag of the op inside the iterative unit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       tag_q <= '0;
    else if (md_start) tag_q <= in_tag;
  end

  // Output register: load, hold while stalled, drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept && !is_md) begin
      out_valid  <= 1'b1;
      out_result <= alu_res;
      out_tag    <= in_tag;
      out_err    <= !one_hot;
    end else if (md_done) begin
      out_valid  <= 1'b1;
      out_result <= md_res;
      out_tag    <= tag_q;
      out_err    <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  alu_muldiv_iter #(
    .W (W)
  ) u_md (
    .clk    (clk),
    .resetn (resetn),
    .start  (md_start),
    .abort  (flush),
    .op     (md_op),
    .a      (in_src1),
    .b      (in_src2),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus handshake, flush
// and reset corner sequences for alu_pipe at W=32.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        in_valid, in_ready;
  logic [15:0] in_op;
  logic [31:0] in_src1, in_src2;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_err, busy;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
    int          lat;
    string       name;
  } vec_t;

  vec_t vq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h want 0x%08h",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] oh(input int i);
    logic [15:0] one;
    one = 16'd1;
    return one << i;
  endfunction

  task automatic run_op(input vec_t v, input logic [4:0] tag);
    int n, nbusy, nrdy;
    in_op     = v.op;
    in_src1   = v.a;
    in_src2   = v.b;
    in_tag    = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({v.name, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_op    = '0;
    in_src1  = '1;
    in_src2  = '1;
    n = 1; nbusy = 0; nrdy = 0;
    while (!out_valid && n < 100) begin
      if (busy) nbusy++;
      if (in_ready) nrdy++;
      step();
      n++;
    end
    chk({v.name, " latency"}, 32'(n), 32'(v.lat));
    chk({v.name, " result"}, out_result, v.exp);
    chk({v.name, " tag"}, 32'(out_tag), 32'(tag));
    chk({v.name, " err"}, 32'(out_err), 32'(v.err));
    chk({v.name, " busy cycles"}, 32'(nbusy), 32'(v.lat - 1));
    if (v.lat > 1)
      chk({v.name, " in_ready while busy"}, 32'(nrdy), 32'd0);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    logic [31:0] b2b_exp [4];
    logic        ordy    [6];
    int          sent, recv, nv;
    logic        held;
    logic [31:0] hv;

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_src1 = '0; in_src2 = '0;
    in_tag = '0; out_ready = 1'b0;
    #12;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset out_tag", 32'(out_tag), 32'd0);
    chk("reset out_err", 32'(out_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("idle in_ready", 32'(in_ready), 32'd1);

    vq.push_back('{oh(OP_ADD), 32'h7FFFFFFF, 32'h1,
                   32'h80000000, 1'b0, 1, "add ovf"});
    vq.push_back('{oh(OP_SUB), 32'h0, 32'h1,
                   32'hFFFFFFFF, 1'b0, 1, "sub wrap"});
    vq.push_back('{oh(OP_SLT), 32'hFFFFFFFF, 32'h1,
                   32'h1, 1'b0, 1, "slt"});
    vq.push_back('{oh(OP_SLTU), 32'hFFFFFFFF, 32'h1,
                   32'h0, 1'b0, 1, "sltu"});
    vq.push_back('{oh(OP_SRA), 32'd31, 32'h80000000,
                   32'hFFFFFFFF, 1'b0, 1, "sra 31"});
    vq.push_back('{oh(OP_SRL), 32'd4, 32'h80000000,
                   32'h08000000, 1'b0, 1, "srl 4"});
    vq.push_back('{oh(OP_SLL), 32'd4, 32'h0000000F,
                   32'h000000F0, 1'b0, 1, "sll 4"});
    vq.push_back('{oh(OP_SLL), 32'hFFFFFFE1, 32'h1,
                   32'h2, 1'b0, 1, "sll shamt mask"});
    vq.push_back('{oh(OP_LUI), 32'h0, 32'h00001234,
                   32'h12340000, 1'b0, 1, "lui"});
    vq.push_back('{oh(OP_LUI), 32'h5, 32'hFFFF1234,
                   32'h12340000, 1'b0, 1, "lui upper"});
    vq.push_back('{oh(OP_OR), 32'hF0, 32'h0F,
                   32'hFF, 1'b0, 1, "or"});
    vq.push_back('{oh(OP_AND), 32'hFF00, 32'h0FF0,
                   32'h0F00, 1'b0, 1, "and"});
    vq.push_back('{oh(OP_XOR), 32'hFF, 32'h0F,
                   32'hF0, 1'b0, 1, "xor"});
    vq.push_back('{oh(OP_NOR), 32'hF0F0F0F0, 32'h0F0F0000,
                   32'h00000F0F, 1'b0, 1, "nor"});
    vq.push_back('{oh(OP_MUL), 32'hFFFFFFFF, 32'd3,
                   32'hFFFFFFFD, 1'b0, 33, "mul -1*3"});
    vq.push_back('{oh(OP_MUL), 32'd6, 32'd7,
                   32'd42, 1'b0, 33, "mul 6*7"});
    vq.push_back('{oh(OP_MULH), 32'h80000000, 32'h80000000,
                   32'h40000000, 1'b0, 33, "mulh min*min"});
    vq.push_back('{oh(OP_MULH), 32'hFFFFFFFF, 32'h1,
                   32'hFFFFFFFF, 1'b0, 33, "mulh -1*1"});
    vq.push_back('{oh(OP_MULH), 32'h7FFFFFFF, 32'h7FFFFFFF,
                   32'h3FFFFFFF, 1'b0, 33, "mulh max*max"});
    vq.push_back('{oh(OP_DIV), 32'd7, 32'd0,
                   32'hFFFFFFFF, 1'b0, 33, "div 7/0"});
    vq.push_back('{oh(OP_REM), 32'd7, 32'd0,
                   32'd7, 1'b0, 33, "rem 7/0"});
    vq.push_back('{oh(OP_DIV), 32'hFFFFFFF9, 32'd0,
                   32'hFFFFFFFF, 1'b0, 33, "div -7/0"});
    vq.push_back('{oh(OP_REM), 32'hFFFFFFF9, 32'd0,
                   32'hFFFFFFF9, 1'b0, 33, "rem -7/0"});
    vq.push_back('{oh(OP_DIV), 32'h80000000, 32'hFFFFFFFF,
                   32'h80000000, 1'b0, 33, "div min/-1"});
    vq.push_back('{oh(OP_REM), 32'h80000000, 32'hFFFFFFFF,
                   32'h0, 1'b0, 33, "rem min/-1"});
    vq.push_back('{oh(OP_REM), 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 1'b0, 33, "rem -7/2"});
    vq.push_back('{oh(OP_DIV), 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFD, 1'b0, 33, "div -7/2"});
    vq.push_back('{oh(OP_DIV), 32'd100, 32'hFFFFFFF9,
                   32'hFFFFFFF2, 1'b0, 33, "div 100/-7"});
    vq.push_back('{oh(OP_REM), 32'd100, 32'hFFFFFFF9,
                   32'd2, 1'b0, 33, "rem 100/-7"});
    vq.push_back('{16'h0003, 32'd5, 32'd6,
                   32'h0, 1'b1, 1, "op 0x0003"});
    vq.push_back('{16'h0000, 32'd5, 32'd6,
                   32'h0, 1'b1, 1, "op 0x0000"});

    for (int i = 0; i < vq.size(); i++)
      run_op(vq[i], 5'(i + 3));

    b2b_exp = '{32'd101, 32'd202, 32'd303, 32'd404};
    ordy    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    sent = 0; recv = 0; held = 1'b0; hv = '0;
    for (int c = 0; c < 12 && recv < 4; c++) begin
      in_valid  = (sent < 4);
      in_op     = oh(OP_ADD);
      in_src1   = 32'(100 * (sent + 1));
      in_src2   = 32'(sent + 1);
      in_tag    = 5'(sent);
      out_ready = (c < 6) ? ordy[c] : 1'b1;
      #1;
      if (held) chk("b2b stall hold", out_result, hv);
      held = 1'b0;
      if (out_valid && out_ready) begin
        chk("b2b result", out_result, b2b_exp[recv]);
        chk("b2b tag", 32'(out_tag), 32'(recv));
        recv++;
      end else if (out_valid) begin
        held = 1'b1;
        hv   = out_result;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    chk("b2b received", 32'(recv), 32'd4);
    chk("b2b drained", 32'(out_valid), 32'd0);

    in_op = oh(OP_DIV); in_src1 = 32'd1000; in_src2 = 32'd3;
    in_tag = 5'd1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("flush pre busy", 32'(busy), 32'd1);
    flush = 1'b1; in_valid = 1'b1;
    in_op = oh(OP_ADD); in_src1 = 32'd1; in_src2 = 32'd2;
    #1;
    chk("flush in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    nv = 0;
    repeat (40) begin
      if (out_valid) nv++;
      step();
    end
    chk("flush no result", 32'(nv), 32'd0);
    v = '{oh(OP_ADD), 32'd5, 32'd6, 32'd11, 1'b0, 1,
          "post-flush add"};
    run_op(v, 5'd9);

    in_op = oh(OP_DIV); in_src1 = 32'd1000; in_src2 = 32'd3;
    in_tag = 5'd2; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("rst pre busy", 32'(busy), 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    nv = 0;
    repeat (40) begin
      if (out_valid) nv++;
      step();
    end
    chk("rst no result", 32'(nv), 32'd0);
    v = '{oh(OP_ADD), 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 1,
          "post-reset add"};
    run_op(v, 5'd17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
